// File: rtl/auto_lock_ctrl.sv
// auto_lock_ctrl: lock-acquisition controller for servo loops.
// Scans until the discriminator rises above the lock threshold. It then
// qualifies the lock and holds it through short dropouts. After too many
// failed attempts it parks in FAULT.
// Optional feature macro: AUTOLOCK_DROP_COUNT_EN adds the drop_count
// lock-loss counter port and register.
module auto_lock_ctrl #(
    parameter int DW = 16,
    parameter int TW = 32,
    parameter int QW = 8,
    parameter int RW = 8
`ifdef AUTOLOCK_DROP_COUNT_EN
    ,
    parameter int CW = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 update,
    input  logic signed [DW-1:0] discriminator,
    input  logic signed [DW-1:0] lock_threshold,
    input  logic signed [DW-1:0] unlock_threshold,
    input  logic        [TW-1:0] timeout,
    input  logic        [QW-1:0] qualify_count,
    input  logic        [RW-1:0] max_retries,
    input  logic                 clear_fault,
    output logic                 enable_lock_out,
    output logic                 scan_enable,
    output logic                 locked,
    output logic                 fault,
    output logic           [2:0] state_out
`ifdef AUTOLOCK_DROP_COUNT_EN
    ,
    output logic        [CW-1:0] drop_count
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEARCH  = 3'd1;
    localparam logic [2:0] S_QUALIFY = 3'd2;
    localparam logic [2:0] S_LOCKED  = 3'd3;
    localparam logic [2:0] S_DROPOUT = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    logic [2:0]    state, state_nxt;
    logic [QW-1:0] qcnt, qcnt_nxt;
    logic [TW-1:0] dcnt, dcnt_nxt;
    logic [RW-1:0] retry, retry_nxt, retry_inc;
    logic          above, below, fail;
`ifdef AUTOLOCK_DROP_COUNT_EN
    logic          drop_evt;
`endif

    // Saturating increment for the retry counter.
    function automatic logic [RW-1:0] sat_inc_rw(input logic [RW-1:0] v);
        return (&v) ? v : v + RW'(1);
    endfunction

`ifdef AUTOLOCK_DROP_COUNT_EN
    // Saturating increment for the lock-loss counter.
    function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction
`endif

    // Signed threshold comparisons; qualified by update inside the FSM.
    assign above     = discriminator > lock_threshold;
    assign below     = discriminator < unlock_threshold;
    assign retry_inc = sat_inc_rw(retry);

    // Next-state and counter logic; enable=0 overrides every transition.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        dcnt_nxt  = dcnt;
        retry_nxt = retry;
        fail      = 1'b0;
`ifdef AUTOLOCK_DROP_COUNT_EN
        drop_evt  = 1'b0;
`endif
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    retry_nxt = '0;
                    state_nxt = S_SEARCH;
                end
                S_SEARCH: begin
                    if (update && above) begin
                        if (qualify_count <= QW'(1)) begin
                            state_nxt = S_LOCKED;
                        end else begin
                            state_nxt = S_QUALIFY;
                            qcnt_nxt  = QW'(1);
                        end
                    end
                end
                S_QUALIFY: begin
                    if (update) begin
                        if (above) begin
                            qcnt_nxt = qcnt + QW'(1);
                            // Widened so qcnt+1 cannot wrap before the compare.
                            if (({1'b0, qcnt} + (QW+1)'(1)) == {1'b0, qualify_count})
                                state_nxt = S_LOCKED;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    retry_nxt = '0;
                    if (update && below) begin
                        state_nxt = S_DROPOUT;
                        dcnt_nxt  = timeout;
                    end
                end
                S_DROPOUT: begin
                    // A recovering sample wins even when the timer has expired.
                    if (update && !below) begin
                        state_nxt = S_LOCKED;
                    end else if (dcnt != '0) begin
                        dcnt_nxt = dcnt - TW'(1);
                    end else begin
                        fail = 1'b1;
`ifdef AUTOLOCK_DROP_COUNT_EN
                        drop_evt = 1'b1;
`endif
                    end
                end
                S_FAULT: begin
                    if (clear_fault)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase

            if (fail) begin
                retry_nxt = retry_inc;
                if ((max_retries != '0) && (retry_inc == max_retries))
                    state_nxt = S_FAULT;
                else
                    state_nxt = S_SEARCH;
            end
        end
    end

    // State, counters and Moore outputs decoded from the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            qcnt            <= '0;
            dcnt            <= '0;
            retry           <= '0;
            enable_lock_out <= 1'b0;
            scan_enable     <= 1'b0;
            locked          <= 1'b0;
            fault           <= 1'b0;
            state_out       <= S_IDLE;
        end else begin
            state           <= state_nxt;
            qcnt            <= qcnt_nxt;
            dcnt            <= dcnt_nxt;
            retry           <= retry_nxt;
            enable_lock_out <= (state_nxt == S_QUALIFY) || (state_nxt == S_LOCKED) ||
                               (state_nxt == S_DROPOUT);
            scan_enable     <= (state_nxt == S_SEARCH);
            locked          <= (state_nxt == S_LOCKED);
            fault           <= (state_nxt == S_FAULT);
            state_out       <= state_nxt;
        end
    end

`ifdef AUTOLOCK_DROP_COUNT_EN
    // Lock-loss counter: one count per dropout that times out; rst only clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_count <= '0;
        else if (drop_evt)
            drop_count <= sat_inc_cw(drop_count);
    end
`endif

endmodule

// File: tb/tb_auto_lock_ctrl.sv
// tb_auto_lock_ctrl: directed table-driven bench for auto_lock_ctrl plus
// hand-written sequences for dropout timing, fault and reset corners.
// Covers the AUTOLOCK_DROP_COUNT_EN build when that macro is defined.
module tb_auto_lock_ctrl;

    localparam logic [2:0] IDLE = 3'd0, SRCH = 3'd1, QUAL = 3'd2,
                           LOCK = 3'd3, DROP = 3'd4, FLT  = 3'd5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               update = 1'b0;
    logic signed [15:0] disc = '0;
    logic signed [15:0] lock_th = 16'sd100;
    logic signed [15:0] unlock_th = 16'sd80;
    logic        [31:0] timeout = 32'd10;
    logic         [7:0] qcount = 8'd3;
    logic         [7:0] max_retries = 8'd0;
    logic               clear_fault = 1'b0;
    logic               enable_lock_out, scan_enable, locked, fault;
    logic         [2:0] state_out;
`ifdef AUTOLOCK_DROP_COUNT_EN
    logic        [15:0] drop_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    auto_lock_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .update           (update),
        .discriminator    (disc),
        .lock_threshold   (lock_th),
        .unlock_threshold (unlock_th),
        .timeout          (timeout),
        .qualify_count    (qcount),
        .max_retries      (max_retries),
        .clear_fault      (clear_fault),
        .enable_lock_out  (enable_lock_out),
        .scan_enable      (scan_enable),
        .locked           (locked),
        .fault            (fault),
        .state_out        (state_out)
`ifdef AUTOLOCK_DROP_COUNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       upd;
        int         d;
        logic [2:0] st;
        logic       elo;
        logic       scan;
        logic       lk;
        logic       flt;
    } vec_t;

    function automatic vec_t mk(input int en, input int upd, input int d, input logic [2:0] st,
                                input int elo, input int scan, input int lk, input int flt);
        vec_t v;
        v.en = (en != 0); v.upd = (upd != 0); v.d = d; v.st = st;
        v.elo = (elo != 0); v.scan = (scan != 0); v.lk = (lk != 0); v.flt = (flt != 0);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int en, input int upd, input int d);
        enable = (en != 0);
        update = (upd != 0);
        disc   = 16'(d);
        tick();
        update = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Compares {state_out, enable_lock_out, scan_enable, locked, fault}.
    task automatic chk_st(input string nm, input logic [2:0] st, input int elo,
                          input int scan, input int lk, input int flt);
        logic [6:0] act, exp;
        act = {state_out, enable_lock_out, scan_enable, locked, fault};
        exp = {st, elo[0], scan[0], lk[0], flt[0]};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {st,elo,scan,lk,flt}=%b_%b expected %b_%b",
                     nm, act[6:4], act[3:0], exp[6:4], exp[3:0]);
        end
    endtask

    task automatic chk_drop(input string nm, input int exp);
`ifdef AUTOLOCK_DROP_COUNT_EN
        chk(nm, int'(drop_count), exp);
`else
        if (exp < 0) $display("%s unused", nm);
`endif
    endtask

    vec_t tbl[23];

    initial begin
        // Table: qualify_count=3, lock=100, unlock=80, timeout=10, unlimited retries.
        tbl[0]  = mk(1, 0,    0, SRCH, 0, 1, 0, 0);
        tbl[1]  = mk(1, 1,   50, SRCH, 0, 1, 0, 0);
        tbl[2]  = mk(1, 1,  150, QUAL, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0,    0, QUAL, 1, 0, 0, 0);
        tbl[4]  = mk(1, 1,  150, QUAL, 1, 0, 0, 0);
        tbl[5]  = mk(1, 1,  150, LOCK, 1, 0, 1, 0);
        tbl[6]  = mk(1, 1,   90, LOCK, 1, 0, 1, 0);
        tbl[7]  = mk(1, 1,   70, DROP, 1, 0, 0, 0);
        tbl[8]  = mk(1, 0,    0, DROP, 1, 0, 0, 0);
        tbl[9]  = mk(1, 0,    0, DROP, 1, 0, 0, 0);
        tbl[10] = mk(1, 0,    0, DROP, 1, 0, 0, 0);
        tbl[11] = mk(1, 0,    0, DROP, 1, 0, 0, 0);
        tbl[12] = mk(1, 1,   90, LOCK, 1, 0, 1, 0);
        tbl[13] = mk(1, 1,   80, LOCK, 1, 0, 1, 0);
        tbl[14] = mk(0, 0,    0, IDLE, 0, 0, 0, 0);
        tbl[15] = mk(1, 0,    0, SRCH, 0, 1, 0, 0);
        tbl[16] = mk(1, 1,  150, QUAL, 1, 0, 0, 0);
        tbl[17] = mk(1, 1,   90, SRCH, 0, 1, 0, 0);
        tbl[18] = mk(1, 1,  100, SRCH, 0, 1, 0, 0);
        tbl[19] = mk(1, 1,  101, QUAL, 1, 0, 0, 0);
        tbl[20] = mk(0, 1,  150, IDLE, 0, 0, 0, 0);
        tbl[21] = mk(1, 0,    0, SRCH, 0, 1, 0, 0);
        tbl[22] = mk(1, 1, -200, SRCH, 0, 1, 0, 0);

        // Reset state
        #2;
        chk_st("reset", IDLE, 0, 0, 0, 0);
        chk_drop("reset_drop", 0);
        tick();
        rst = 1'b0;
        chk_st("after_reset_idle", IDLE, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].en, tbl[i].upd, tbl[i].d);
            chk_st($sformatf("vec%0d", i), tbl[i].st, tbl[i].elo, tbl[i].scan, tbl[i].lk, tbl[i].flt);
        end
        chk_drop("table_drop", 0);

        // Dropout timeout: SEARCH exactly 11 edges after DROPOUT entry
        qcount = 8'd1;
        step(1, 1, 150); chk_st("to_lock_qc1", LOCK, 1, 0, 1, 0);
        step(1, 1, 70);  chk_st("to_drop_t10", DROP, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            chk_st($sformatf("hold_drop_e%0d", i), DROP, 1, 0, 0, 0);
        end
        step(1, 0, 0); chk_st("timeout_exit", SRCH, 0, 1, 0, 0);
        chk_drop("drop_after_timeout", 1);

        // timeout=0 exits on the next edge; qualify_count=0 acts as 1
        qcount = 8'd0; timeout = 32'd0;
        step(1, 1, 150); chk_st("to_lock_qc0", LOCK, 1, 0, 1, 0);
        step(1, 1, 70);  chk_st("to_drop_t0", DROP, 1, 0, 0, 0);
        step(1, 0, 0);   chk_st("t0_exit", SRCH, 0, 1, 0, 0);
        chk_drop("drop_after_t0", 2);

        // Recovery on the edge where the timer is already at zero wins
        timeout = 32'd2;
        step(1, 1, 150); chk_st("to_lock_t2", LOCK, 1, 0, 1, 0);
        step(1, 1, 70);  chk_st("to_drop_t2", DROP, 1, 0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);   chk_st("t2_dcnt0", DROP, 1, 0, 0, 0);
        step(1, 1, 90);  chk_st("late_recover", LOCK, 1, 0, 1, 0);
        chk_drop("drop_after_recover", 2);

        // Fault after two qualify failures, then clear_fault
        qcount = 8'd3; max_retries = 8'd2; timeout = 32'd10;
        step(0, 0, 0);   chk_st("f_idle", IDLE, 0, 0, 0, 0);
        step(1, 0, 0);   chk_st("f_search", SRCH, 0, 1, 0, 0);
        step(1, 1, 150); chk_st("f_qual1", QUAL, 1, 0, 0, 0);
        step(1, 1, 90);  chk_st("f_fail1", SRCH, 0, 1, 0, 0);
        step(1, 1, 150); chk_st("f_qual2", QUAL, 1, 0, 0, 0);
        step(1, 1, 90);  chk_st("f_fault", FLT, 0, 0, 0, 1);
        step(1, 1, 150); chk_st("f_fault_hold", FLT, 0, 0, 0, 1);
        clear_fault = 1'b1;
        step(1, 0, 0);   chk_st("f_clear", IDLE, 0, 0, 0, 0);
        clear_fault = 1'b0;
        step(1, 0, 0);   chk_st("f_research", SRCH, 0, 1, 0, 0);

        // LOCKED clears retries; a timed-out dropout counts as one failure
        step(1, 1, 150); chk_st("r_qual", QUAL, 1, 0, 0, 0);
        step(1, 1, 90);  chk_st("r_fail1", SRCH, 0, 1, 0, 0);
        qcount = 8'd1; timeout = 32'd0;
        step(1, 1, 150); chk_st("r_lock", LOCK, 1, 0, 1, 0);
        step(1, 1, 70);  chk_st("r_drop", DROP, 1, 0, 0, 0);
        step(1, 0, 0);   chk_st("r_drop_fail", SRCH, 0, 1, 0, 0);
        chk_drop("drop_retry", 3);
        qcount = 8'd3;
        step(1, 1, 150); chk_st("r_qual2", QUAL, 1, 0, 0, 0);
        step(1, 1, 90);  chk_st("r_fault", FLT, 0, 0, 0, 1);
        step(0, 0, 0);   chk_st("r_fault_disable", IDLE, 0, 0, 0, 0);
        chk_drop("drop_kept_disable", 3);

        // Asynchronous reset in the middle of a dropout
        qcount = 8'd1; timeout = 32'd10;
        step(1, 0, 0);   chk_st("a_search", SRCH, 0, 1, 0, 0);
        step(1, 1, 150); chk_st("a_lock", LOCK, 1, 0, 1, 0);
        step(1, 1, 70);  chk_st("a_drop", DROP, 1, 0, 0, 0);
        step(1, 0, 0);
        #3; rst = 1'b1; #1;
        chk_st("async_rst", IDLE, 0, 0, 0, 0);
        chk_drop("drop_async_rst", 0);
        tick();
        rst = 1'b0;
        step(1, 0, 0);   chk_st("a_restart", SRCH, 0, 1, 0, 0);

        // enable dropped in LOCKED: IDLE on the next edge, drop_count kept
        timeout = 32'd0;
        step(1, 1, 150); chk_st("e_lock1", LOCK, 1, 0, 1, 0);
        step(1, 1, 70);  chk_st("e_drop", DROP, 1, 0, 0, 0);
        step(1, 0, 0);   chk_st("e_search", SRCH, 0, 1, 0, 0);
        step(1, 1, 150); chk_st("e_lock2", LOCK, 1, 0, 1, 0);
        step(0, 0, 0);   chk_st("e_disable", IDLE, 0, 0, 0, 0);
        chk_drop("drop_kept_locked_disable", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
